// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity stream scheduler: FSM encoding,
// beat width and the wrap-around round-robin priority pick.
package parity_pkg;

  localparam int DATA_W    = 16;
  localparam int MAX_REQ   = 8;
  localparam int MAX_REQ_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // First set index at or after ptr, wrapping at nreq; returns ptr when none set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int nreq);
    int   sel;
    int   idx;
    logic found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= nreq) begin
        idx = idx - nreq;
      end
      if ((i < nreq) && !found && valid[idx[MAX_REQ_W-1:0]]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/parity16.sv
// Combinational 16-bit even-parity evaluator shared by all requesters.
module parity16
  import parity_pkg::*;
(
  input  logic [DATA_W-1:0] d_i,
  output logic              p_o
);

  assign p_o = ^d_i;

endmodule

// File: rtl/parity_stream_sched.sv
// Round-robin scheduler that locks one requester per message, XOR-accumulates
// beat parity through a single shared evaluator and returns a tagged result.
module parity_stream_sched
  import parity_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int BEAT_W = 8,
  parameter bit ODD    = 1'b0,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_parity,
  output logic [ID_W-1:0]          res_id,
  output logic [BEAT_W-1:0]        res_beats,
  output logic                     res_sat
);

  localparam logic [BEAT_W-1:0] CNT_MAX = {BEAT_W{1'b1}};
  localparam logic [NREQ-1:0]   ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     grant_q;
  logic                acc_q;
  logic [BEAT_W-1:0]   cnt_q;
  logic                sat_q;
  logic [NREQ-1:0]     req_ready_q;
  logic                res_valid_q;
  logic                res_parity_q;
  logic [ID_W-1:0]     res_id_q;
  logic [BEAT_W-1:0]   res_beats_q;
  logic                res_sat_q;

  logic [MAX_REQ-1:0]  valid_ext_s;
  logic [ID_W-1:0]     pick_s;
  logic [ID_W-1:0]     next_ptr_s;
  logic [DATA_W-1:0]   gnt_data_s;
  logic                gnt_valid_s;
  logic                gnt_last_s;
  logic                beat_par_s;
  logic                acc_d;
  logic [BEAT_W-1:0]   cnt_d;
  logic                sat_d;

  // Arbitration pick and grant-side beat mux.
  always_comb begin
    valid_ext_s              = {MAX_REQ{1'b0}};
    valid_ext_s[NREQ-1:0]    = req_valid;
    pick_s                   = ID_W'(rr_pick(valid_ext_s, int'(rr_ptr_q), NREQ));
    next_ptr_s               = (grant_q == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : grant_q + ID_W'(1);
    gnt_data_s               = {DATA_W{1'b0}};
    for (int r = 0; r < NREQ; r++) begin
      gnt_data_s = (grant_q == ID_W'(r)) ? req_data[r*DATA_W +: DATA_W] : gnt_data_s;
    end
    gnt_valid_s              = req_valid[grant_q];
    gnt_last_s               = req_last[grant_q];
  end

  parity16 u_par (
    .d_i (gnt_data_s),
    .p_o (beat_par_s)
  );

  // Accumulator and saturating beat counter as they stand after this beat.
  always_comb begin
    acc_d = acc_q ^ beat_par_s;
    if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
      sat_d = 1'b1;
    end else begin
      cnt_d = cnt_q + BEAT_W'(1);
      sat_d = sat_q;
    end
  end

  // Message FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= {ID_W{1'b0}};
      grant_q      <= {ID_W{1'b0}};
      acc_q        <= 1'b0;
      cnt_q        <= {BEAT_W{1'b0}};
      sat_q        <= 1'b0;
      req_ready_q  <= {NREQ{1'b0}};
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= {ID_W{1'b0}};
      res_beats_q  <= {BEAT_W{1'b0}};
      res_sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= {NREQ{1'b0}};
          if (|req_valid) begin
            grant_q     <= pick_s;
            req_ready_q <= ONE_HOT0 << pick_s;
            acc_q       <= 1'b0;
            cnt_q       <= {BEAT_W{1'b0}};
            sat_q       <= 1'b0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_valid_s) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            // Last beat: result reflects this beat, grant released at once.
            if (gnt_last_s) begin
              req_ready_q  <= {NREQ{1'b0}};
              res_valid_q  <= 1'b1;
              res_parity_q <= acc_d ^ ODD;
              res_id_q     <= grant_q;
              res_beats_q  <= cnt_d;
              res_sat_q    <= sat_d;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            rr_ptr_q    <= next_ptr_s;
            state_q     <= IDLE;
          end
        end
        default: begin
          req_ready_q <= {NREQ{1'b0}};
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign res_valid  = res_valid_q;
  assign res_parity = res_parity_q;
  assign res_id     = res_id_q;
  assign res_beats  = res_beats_q;
  assign res_sat    = res_sat_q;

endmodule

// File: tb/tb_parity_stream_sched.sv
// Directed bench: three scheduler instances share stimulus (default, odd-sense,
// 2-bit beat counter) so parity sense and saturation are checked alongside.
module tb_parity_stream_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic        res_ready;

  logic [3:0]  req_ready, o_req_ready, s_req_ready;
  logic        res_valid, o_res_valid, s_res_valid;
  logic        res_parity, o_res_parity, s_res_parity;
  logic [1:0]  res_id, o_res_id, s_res_id;
  logic [7:0]  res_beats, o_res_beats;
  logic [1:0]  s_res_beats;
  logic        res_sat, o_res_sat, s_res_sat;

  int checks;
  int failures;

  parity_stream_sched #(.NREQ(4), .BEAT_W(8), .ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_parity(res_parity), .res_id(res_id),
    .res_beats(res_beats), .res_sat(res_sat));

  parity_stream_sched #(.NREQ(4), .BEAT_W(8), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(o_req_ready), .res_valid(o_res_valid),
    .res_ready(res_ready), .res_parity(o_res_parity), .res_id(o_res_id),
    .res_beats(o_res_beats), .res_sat(o_res_sat));

  parity_stream_sched #(.NREQ(4), .BEAT_W(2), .ODD(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(s_req_ready), .res_valid(s_res_valid),
    .res_ready(res_ready), .res_parity(s_res_parity), .res_id(s_res_id),
    .res_beats(s_res_beats), .res_sat(s_res_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on port r and return once the accepting edge has passed.
  task automatic send_beat(input int r, input logic [15:0] d, input logic last, output int waits);
    waits = 0;
    req_valid[r]          = 1'b1;
    req_data[r*16 +: 16]  = d;
    req_last[r]           = last;
    while (!req_ready[r] && waits < 20) begin
      step();
      waits++;
    end
    if (!req_ready[r]) check_eq("accept_timeout", 32'd0, 32'd1);
    step();
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic par, input logic [1:0] id,
                             input logic [7:0] beats, input logic sat);
    check_eq({tag, "_valid"},  32'(res_valid),  32'd1);
    check_eq({tag, "_parity"}, 32'(res_parity), 32'(par));
    check_eq({tag, "_id"},     32'(res_id),     32'(id));
    check_eq({tag, "_beats"},  32'(res_beats),  32'(beats));
    check_eq({tag, "_sat"},    32'(res_sat),    32'(sat));
    res_ready = 1'b1;
    step();
    check_eq({tag, "_released"}, 32'(res_valid), 32'd0);
    res_ready = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ready"},  32'(req_ready),  32'd0);
    check_eq({tag, "_valid"},  32'(res_valid),  32'd0);
    check_eq({tag, "_parity"}, 32'(res_parity), 32'd0);
    check_eq({tag, "_id"},     32'(res_id),     32'd0);
    check_eq({tag, "_beats"},  32'(res_beats),  32'd0);
    check_eq({tag, "_sat"},    32'(res_sat),    32'd0);
  endtask

  initial begin
    int w;
    int got;
    int seen;
    int exp_id  [5] = '{0, 1, 2, 3, 0};
    int exp_par [4] = '{1, 0, 1, 0};

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_data  = 64'h0;
    req_last  = 4'h0;
    res_ready = 1'b0;
    step();
    step();
    check_zero_outputs("rst");
    rst_n = 1'b1;

    // Single-beat message: accepted one cycle after arbitration.
    send_beat(0, 16'h0001, 1'b1, w);
    check_eq("t2_wait", 32'(w), 32'd1);
    check_eq("t2_odd_parity", 32'(o_res_parity), 32'd0);
    take_result("t2", 1'b1, 2'd0, 8'd1, 1'b0);

    // Three-beat message, without and with idle gaps between beats.
    for (int g = 0; g <= 2; g += 2) begin
      send_beat(2, 16'hFFFF, 1'b0, w);
      for (int k = 0; k < g; k++) begin
        step();
        check_eq("t3_gap_ready", 32'(req_ready), 32'h4);
      end
      send_beat(2, 16'h0003, 1'b0, w);
      for (int k = 0; k < g; k++) begin
        step();
        check_eq("t3_gap_ready", 32'(req_ready), 32'h4);
      end
      send_beat(2, 16'h0100, 1'b1, w);
      take_result("t3", 1'b1, 2'd2, 8'd3, 1'b0);
    end

    // Reset in the middle of a message discards it.
    for (int b = 0; b < 3; b++) send_beat(0, 16'h0001, 1'b0, w);
    rst_n = 1'b0;
    step();
    check_zero_outputs("t1");
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (res_valid || req_ready != 4'h0) seen = 1;
    end
    check_eq("t1_no_result", 32'(seen), 32'd0);

    // Round-robin with every port requesting continuously.
    req_data  = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    req_last  = 4'hF;
    req_valid = 4'hF;
    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      step();
      if (req_ready != 4'h0) check_eq("t4_ready_onehot", 32'(req_ready), 32'd1 << exp_id[got]);
      if (res_valid) begin
        check_eq("t4_id", 32'(res_id), 32'(exp_id[got]));
        check_eq("t4_parity", 32'(res_parity), 32'(exp_par[exp_id[got]]));
        got++;
        if (got == 5) req_valid = 4'h0;
      end
    end
    check_eq("t4_count", 32'(got), 32'd5);
    step();
    res_ready = 1'b0;
    req_last  = 4'h0;
    check_eq("t4_idle", 32'(res_valid), 32'd0);

    // Backpressure holds the result while another port waits.
    send_beat(1, 16'h8000, 1'b1, w);
    req_valid[3]     = 1'b1;
    req_data[63:48]  = 16'h0003;
    req_last[3]      = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("t5_hold_valid",  32'(res_valid),  32'd1);
      check_eq("t5_hold_parity", 32'(res_parity), 32'd1);
      check_eq("t5_hold_id",     32'(res_id),     32'd1);
      check_eq("t5_hold_beats",  32'(res_beats),  32'd1);
      check_eq("t5_hold_ready",  32'(req_ready),  32'd0);
    end
    res_ready = 1'b1;
    step();
    check_eq("t5_release_valid", 32'(res_valid), 32'd0);
    check_eq("t5_release_ready", 32'(req_ready), 32'd0);
    res_ready = 1'b0;
    step();
    check_eq("t5_next_grant", 32'(req_ready), 32'h8);
    send_beat(3, 16'h0003, 1'b1, w);
    take_result("t5b", 1'b0, 2'd3, 8'd1, 1'b0);

    // Five beats: the 2-bit counter saturates at 3, the 8-bit one counts 5.
    for (int b = 0; b < 5; b++) send_beat(0, 16'h0001, (b == 4), w);
    check_eq("t6_sat_beats",  32'(s_res_beats),  32'd3);
    check_eq("t6_sat_flag",   32'(s_res_sat),    32'd1);
    check_eq("t6_sat_parity", 32'(s_res_parity), 32'd1);
    take_result("t6", 1'b1, 2'd0, 8'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
